regfile_arbiter: RTL and testbench
==================================

Name: regfile_arbiter

Overview:
- Shares one single-port 8-entry x 8-bit register bank between two requesters, A and B.
- Uses a registered round-robin grant state machine with a bounded burst length.
- Each granted cycle performs exactly one read or write beat. Read data is returned one cycle later, tagged with the requester that issued it.
- Sits between the pin-level command decoders and the storage inside the tt_um register project.

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; bank depth = 2**ADDR_W
- MAX_BURST, 4, maximum consecutive beats granted to one requester while the other is waiting (legal range 1..15)

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- a_req  input  1  requester A wants a beat this cycle
- a_we  input  1  A: 1 = write, 0 = read
- a_addr  input  ADDR_W  A register address
- a_wdata  input  DATA_W  A write data
- a_gnt  output  1  A's beat is accepted on this cycle's rising edge
- b_req  input  1  requester B wants a beat this cycle
- b_we  input  1  B: 1 = write, 0 = read
- b_addr  input  ADDR_W  B register address
- b_wdata  input  DATA_W  B write data
- b_gnt  output  1  B's beat is accepted on this cycle's rising edge
- rdata  output  DATA_W  read data, registered
- rvalid  output  1  rdata is valid this cycle (one-cycle pulse per read beat)
- rid  output  1  owner of rdata: 0 = A, 1 = B
- busy  output  1  state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous), all of the following take effect immediately:
  - state = IDLE, last-served pointer = B (so A wins the first tie), beat counter = 0.
  - All bank entries = 0.
  - rdata = 0, rvalid = 0, rid = 0, busy = 0.
  - a_gnt = b_gnt = 0, because both are decoded from the state.
- Reset mid-burst aborts the burst. Any pending read is discarded: rvalid stays 0 after release.
- States: IDLE, OWN_A, OWN_B.
- Grants are combinational from state and request:
  - a_gnt = (state == OWN_A) & a_req
  - b_gnt = (state == OWN_B) & b_req
- A beat occurs on a rising edge while the requester's gnt is high.
  - Write beat: bank[addr] <= wdata.
  - Read beat: rdata <= bank[addr], rvalid <= 1, rid <= owner, all on that edge.
- rvalid is 0 on every cycle that follows a non-read edge.
- Read latency is one cycle after the granted cycle.
- Read-after-write to the same address on consecutive beats returns the new value. Reads are taken from the bank after the earlier write has committed.
- IDLE transitions:
  - a_req & b_req -> owner = requester opposite the last-served pointer.
  - Only one request -> OWN_ of that requester.
  - No request -> stay in IDLE.
  - Entering any OWN state clears the beat counter and sets last-served to the new owner.
  - IDLE costs one cycle of arbitration latency: no grant is issued in IDLE.
- OWN_x transitions, evaluated each edge (y = the other requester):
  - x_req low and y_req high -> OWN_y.
  - x_req low and y_req low -> IDLE.
  - Beat taken with counter == MAX_BURST-1 and y_req high -> OWN_y (forced rotation). No idle cycle is inserted, so y's grant is visible the next cycle.
  - Beat taken otherwise -> stay in OWN_x and increment the counter. The counter saturates at MAX_BURST-1 while y is not requesting; the owner keeps the bank indefinitely if y is idle.
- Requester protocol:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - Dropping req before gnt is legal: the beat is simply not performed.
- Simultaneous events:
  - Both requests rise together from IDLE -> fair tie-break by the pointer.
  - y_req rises on the same edge as x's last burst beat -> rotation happens on that edge.
- Address wrap: not applicable. The full ADDR_W range is valid and there is no out-of-range case.

Test Plan:
- Reset, then read all 8 addresses via A -> each rdata = 0x00, rvalid one cycle after each a_gnt, rid = 0, busy = 1 while requesting.
- A writes 0x5A to addr 3, then reads addr 3 on the next beat -> rdata = 0x5A one cycle after the read gnt.
- A and B both assert req continuously from IDLE, MAX_BURST = 4 -> grant pattern AAAA BBBB AAAA…; no cycle with both gnt high; no idle cycle at rotation.
- Only B requests for 10 beats while A is idle -> b_gnt high every cycle after the single IDLE cycle; no rotation; counter saturates.
- B writes 0xC3 to addr 7 and then A reads addr 7 after rotation -> A receives 0xC3 with rid = 0.
- Assert rst_n low mid-burst, right after a read beat -> rvalid = 0 immediately, state IDLE, bank cleared; next read of the same address returns 0x00.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter in front of a single-port register bank.
// Round-robin ownership with bounded bursts; read data returns one cycle after the grant, tagged with its owner.
module regfile_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rid,
    output logic              busy
);

    localparam int         DEPTH      = 1 << ADDR_W;
    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_bank [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;
    logic              r_rid;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_gnt;
    logic              w_owner;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    assign w_a_gnt = (r_state == OWN_A) && a_req;
    assign w_b_gnt = (r_state == OWN_B) && b_req;
    assign w_gnt   = w_a_gnt || w_b_gnt;
    assign w_owner = (r_state == OWN_B);
    assign w_we    = w_owner ? b_we    : a_we;
    assign w_addr  = w_owner ? b_addr  : a_addr;
    assign w_wdata = w_owner ? b_wdata : a_wdata;

    // r_last: 0 = A served last, 1 = B served last; the other side wins a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (a_req && (!b_req || r_last)) begin
                        r_state <= OWN_A;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (b_req) begin
                        r_state <= OWN_B;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                OWN_A: begin
                    if (!a_req) begin
                        if (b_req) begin
                            r_state <= OWN_B;
                            r_last  <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if ((r_cnt == BURST_LAST) && b_req) begin
                        r_state <= OWN_B;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_cnt != BURST_LAST) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                OWN_B: begin
                    if (!b_req) begin
                        if (a_req) begin
                            r_state <= OWN_A;
                            r_last  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else if ((r_cnt == BURST_LAST) && a_req) begin
                        r_state <= OWN_A;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt != BURST_LAST) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A read on the beat after a write sees the committed value, since the write lands on the earlier edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_rid    <= 1'b0;
        end else begin
            r_rvalid <= w_gnt && !w_we;
            if (w_gnt && w_we) begin
                r_bank[w_addr] <= w_wdata;
            end
            if (w_gnt && !w_we) begin
                r_rdata <= r_bank[w_addr];
                r_rid   <= w_owner;
            end
        end
    end

    assign a_gnt  = w_a_gnt;
    assign b_gnt  = w_b_gnt;
    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign rid    = r_rid;
    assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: stimulus pushes expected reads, a monitor pops them on rvalid.
module tb_regfile_arbiter;

    logic       clk;
    logic       rst_n;
    logic       a_req, a_we, b_req, b_we;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt;
    logic [7:0] rdata;
    logic       rvalid, rid, busy;

    typedef struct {
        logic [7:0] d;
        logic       id;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   w;

    regfile_arbiter #(.DATA_W(8), .ADDR_W(3), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_gnt(b_gnt),
        .rdata(rdata), .rvalid(rvalid), .rid(rid), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_grant", {31'd0, a_gnt && b_gnt}, 32'd0);
            if (rvalid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rdata", {24'd0, rdata}, {24'd0, e.d});
                    chk("rid", {31'd0, rid}, {31'd0, e.id});
                    chk("rlatency", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one beat for requester who (0=A, 1=B); reads push expected data; waits = idle cycles before grant
    task automatic beat(input logic who, input logic we, input logic [2:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp, output int waits);
        logic granted;
        exp_t e;
        granted = 1'b0;
        waits   = 0;
        if (!who) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end
        while (!granted && waits < 20) begin
            @(negedge clk);
            if ((!who && a_gnt) || (who && b_gnt)) begin
                granted = 1'b1;
                chk("busy_on_gnt", {31'd0, busy}, 32'd1);
                if (!we) begin
                    e.d = exp; e.id = who; e.cyc = cyc + 1;
                    q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if (!granted) waits++;
        end
        if (!granted) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        a_req = 1'b0; b_req = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        #2;
        rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        @(negedge clk);
        chk("rst_rdata", {24'd0, rdata}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rid", {31'd0, rid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        rst_n = 1'b1;

        // Read all addresses through A after reset
        for (int i = 0; i < 8; i++) begin
            beat(1'b0, 1'b0, 3'(i), 8'h00, 8'h00, w);
            chk("a_read_wait", w, (i == 0) ? 1 : 0);
        end
        idle(3);

        // Write then read back on the next beat
        beat(1'b0, 1'b1, 3'd3, 8'h5A, 8'h00, w);
        beat(1'b0, 1'b0, 3'd3, 8'h00, 8'h5A, w);
        chk("raw_wait", w, 0);
        idle(3);

        // Both requesting continuously: IDLE, then AAAA BBBB AAAA
        do_reset();
        a_req = 1'b1; a_we = 1'b1; a_addr = 3'd0; a_wdata = 8'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 3'd1; b_wdata = 8'h22;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            chk("rot_a_gnt", {31'd0, a_gnt}, {31'd0, ((i >= 1 && i <= 4) || (i >= 9 && i <= 12))});
            chk("rot_b_gnt", {31'd0, b_gnt}, {31'd0, (i >= 5 && i <= 8)});
        end
        @(posedge clk); #1;
        idle(2);
        do_reset();

        // B alone for 10 beats: one IDLE cycle, then a grant every cycle
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, 1'b1, 3'(i % 4), 8'(i), 8'h00, w);
            chk("b_solo_wait", w, (i == 0) ? 1 : 0);
        end
        beat(1'b1, 1'b1, 3'd7, 8'hC3, 8'h00, w);
        chk("b_c3_wait", w, 0);
        // B keeps requesting with a saturated counter; A's request forces rotation after one more B beat
        beat(1'b0, 1'b0, 3'd7, 8'h00, 8'hC3, w);
        chk("a_after_rot_wait", w, 1);
        idle(3);

        // Reset right after a read beat aborts the pending read and clears the bank
        beat(1'b0, 1'b1, 3'd2, 8'h77, 8'h00, w);
        beat(1'b0, 1'b0, 3'd2, 8'h00, 8'h77, w);
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd4;
        @(negedge clk);
        chk("pre_rst_gnt", {31'd0, a_gnt}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_a_gnt", {31'd0, a_gnt}, 32'd0);
        chk("mid_rst_rdata", {24'd0, rdata}, 32'd0);
        a_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat(1'b0, 1'b0, 3'd2, 8'h00, 8'h00, w);
        idle(4);

        chk("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
